// File: rtl/fifo_rd_burst_ctrl.sv
//==============================================================================
// Module      : fifo_rd_burst_ctrl
// Description : Read-side burst controller for a dual-clock FIFO. On a start
//               command it pops exactly burst_len words from the FIFO and
//               presents them on a valid/ready stream. A 3-entry output buffer
//               absorbs the FIFO's one-cycle read latency so that consumer
//               backpressure never loses a word. Completion, the delivered
//               word count and a sticky underflow error are reported.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   rd_clk        in   read clock; all logic on its rising edge
//   res           in   synchronous active-high reset
//   start         in   one-cycle burst request, sampled only in IDLE
//   burst_len     in   words to pop, latched on an accepted start
//   empty         in   FIFO empty flag
//   underflow     in   FIFO underflow flag, valid the cycle after rd_en
//   rd_en         out  FIFO pop request (combinational)
//   rdata         in   FIFO read data, valid the cycle after rd_en
//   out_valid     out  output word available
//   out_data      out  output word (buffer head)
//   out_ready     in   consumer accepts when out_valid && out_ready
//   out_last      out  final word of a non-aborted burst
//   busy          out  high while reading or draining
//   done          out  one-cycle completion pulse
//   words_read    out  words handshaken out since the last accepted start
//   err_underflow out  sticky underflow error, cleared by res or start
//==============================================================================
`default_nettype none

module fifo_rd_burst_ctrl #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input  logic             rd_clk,
    input  logic             res,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    input  logic             empty,
    input  logic             underflow,
    output logic             rd_en,
    input  logic [WIDTH-1:0] rdata,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] words_read,
    output logic             err_underflow
);

    //--------------------------------------------------------------------------
    // Constants and types
    //--------------------------------------------------------------------------
    localparam int               c_DEPTH = 3;
    localparam logic [LEN_W-1:0] c_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] c_ZERO  = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    //--------------------------------------------------------------------------
    // Registers
    //--------------------------------------------------------------------------
    state_t           r_state;
    logic [LEN_W-1:0] r_len;       // latched burst length
    logic [LEN_W-1:0] r_issued;    // rd_en pulses issued in this burst
    logic [LEN_W-1:0] r_words;     // words handshaken out in this burst
    logic             r_inflight;  // a read response arrives this cycle
    logic             r_abort;     // burst was cut short by an underflow
    logic             r_err;
    logic             r_busy;
    logic             r_done;

    // Output buffer: circular, head/tail wrap at c_DEPTH
    logic [WIDTH-1:0] r_buf [c_DEPTH];
    logic [1:0]       r_occ;
    logic [1:0]       r_head;
    logic [1:0]       r_tail;

    //--------------------------------------------------------------------------
    // Combinational control
    //--------------------------------------------------------------------------
    logic             w_uf_abort;
    logic             w_push;
    logic             w_pop;
    logic             w_credit;
    logic [LEN_W-1:0] w_len_m1;

    // A response flagged as underflow is discarded and ends issuing.
    assign w_uf_abort = r_inflight && underflow;
    assign w_push     = r_inflight && !underflow;
    assign w_pop      = (r_occ != 2'd0) && out_ready;

    // Every issued read needs a guaranteed buffer slot when its data lands:
    // words already buffered plus the one in flight must leave room.
    assign w_credit   = ({1'b0, r_occ} + {2'b00, r_inflight}) < 3'd3;

    // The abort term stops the read that would otherwise be issued in the
    // same cycle the underflowed response is seen. out_ready is deliberately
    // absent so the FIFO side never waits on the consumer combinationally.
    assign rd_en      = (r_state == S_BURST) && !empty && (r_issued < r_len)
                        && w_credit && !w_uf_abort;

    assign w_len_m1   = r_len - c_ONE;

    //--------------------------------------------------------------------------
    // Output stream
    //--------------------------------------------------------------------------
    // Head data and the last flag depend only on registers that cannot move
    // without a handshake, so both hold stable under backpressure.
    assign out_valid     = (r_occ != 2'd0);
    assign out_data      = r_buf[r_head];
    assign out_last      = out_valid && !r_abort && (r_words == w_len_m1);
    assign busy          = r_busy;
    assign done          = r_done;
    assign words_read    = r_words;
    assign err_underflow = r_err;

    //--------------------------------------------------------------------------
    // Pointer advance with wrap at the buffer depth
    //--------------------------------------------------------------------------
    function automatic logic [1:0] f_next_ptr(input logic [1:0] i_ptr);
        f_next_ptr = (i_ptr == 2'(c_DEPTH - 1)) ? 2'd0 : i_ptr + 2'd1;
    endfunction

    //--------------------------------------------------------------------------
    // Datapath, counters and state machine
    //--------------------------------------------------------------------------
    always_ff @(posedge rd_clk) begin
        if (res) begin
            r_state    <= S_IDLE;
            r_len      <= c_ZERO;
            r_issued   <= c_ZERO;
            r_words    <= c_ZERO;
            r_inflight <= 1'b0;
            r_abort    <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_occ      <= 2'd0;
            r_head     <= 2'd0;
            r_tail     <= 2'd0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_inflight <= rd_en;

            if (rd_en) begin
                r_issued <= r_issued + c_ONE;
            end

            // Capture a good response at the tail; the credit rule ensures
            // the buffer is never full here.
            if (w_push) begin
                r_buf[r_tail] <= rdata;
                r_tail        <= f_next_ptr(r_tail);
            end

            if (w_pop) begin
                r_head  <= f_next_ptr(r_head);
                r_words <= r_words + c_ONE;
            end

            // Simultaneous push and pop leave occupancy unchanged.
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase

            if (w_uf_abort) begin
                r_abort <= 1'b1;
                r_err   <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len    <= burst_len;
                        r_issued <= c_ZERO;
                        r_words  <= c_ZERO;
                        r_err    <= 1'b0;
                        r_abort  <= 1'b0;
                        if (burst_len != c_ZERO) begin
                            r_state <= S_BURST;
                            r_busy  <= 1'b1;
                        end else begin
                            // Zero-length burst completes without reading.
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                S_BURST: begin
                    if (w_uf_abort || (r_issued == r_len)) begin
                        r_state <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    // Finish only once every issued read has landed and every
                    // buffered word has been handed to the consumer.
                    if ((r_occ == 2'd0) && !r_inflight) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_burst_ctrl.sv
//==============================================================================
// Module      : tb_fifo_rd_burst_ctrl
// Description : Self-checking bench for fifo_rd_burst_ctrl. A queue-based FIFO
//               model feeds the DUT; a transaction-level model predicts every
//               output each cycle; directed scenarios add literal checks.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fifo_rd_burst_ctrl;

    localparam int WIDTH = 8;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             res = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] burst_len = '0;
    logic             empty = 1'b1;
    logic             underflow = 1'b0;
    logic             rd_en;
    logic [WIDTH-1:0] rdata = '0;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b0;
    logic             out_last;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] words_read;
    logic             err_underflow;

    always #5 clk = ~clk;

    fifo_rd_burst_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .rd_clk        (clk),
        .res           (res),
        .start         (start),
        .burst_len     (burst_len),
        .empty         (empty),
        .underflow     (underflow),
        .rd_en         (rd_en),
        .rdata         (rdata),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .busy          (busy),
        .done          (done),
        .words_read    (words_read),
        .err_underflow (err_underflow)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    //--------------------------------------------------------------------------
    // FIFO model: pop on the edge after rd_en, data/underflow valid next cycle
    //--------------------------------------------------------------------------
    logic [WIDTH-1:0] fq[$];
    bit pop_req  = 1'b0;
    int rd_cnt   = 0;
    int force_uf = 0;   // 1-based index of the read response to flag

    always @(posedge clk) begin
        #1;
        underflow = 1'b0;
        if (pop_req) begin
            rd_cnt++;
            if (fq.size() > 0) rdata = fq.pop_front();
            underflow = (force_uf != 0) && (rd_cnt == force_uf);
        end
        empty = (fq.size() == 0);
    end

    //--------------------------------------------------------------------------
    // Transaction model and per-cycle compare
    //--------------------------------------------------------------------------
    bit m_active = 0, m_abort = 0, m_err = 0, m_done = 0, m_inflt = 0;
    int m_len = 0, m_issued = 0, m_hs = 0, m_disc = 0, m_wr = 0;
    logic [WIDTH-1:0] eq[$];
    bit chk_en = 0;
    bit p_stall = 0;
    logic [WIDTH-1:0] p_data;
    logic p_last;
    int cyc = 0, start_cyc = 0, done_cnt = 0, done_cyc = -1;
    int rd_log[$];
    int hs_cyc[$];
    logic [WIDTH-1:0] hs_data[$];
    bit hs_last[$];

    always @(negedge clk) begin
        bit uf_now, e_rd, e_valid, e_last, fin, nd;
        int outst;
        if (chk_en) begin
            uf_now  = m_inflt && underflow;
            outst   = m_issued - m_hs - m_disc;
            e_rd    = m_active && !m_abort && !uf_now && !empty && (m_issued < m_len) && (outst < 3);
            e_valid = (eq.size() != 0);
            e_last  = e_valid && !m_abort && (m_wr == m_len - 1);
            check("rd_en", rd_en, e_rd);
            check("out_valid", out_valid, e_valid);
            if (e_valid) check("out_data", out_data, eq[0]);
            check("out_last", out_last, e_last);
            check("busy", busy, m_active);
            check("done", done, m_done);
            check("words_read", words_read, m_wr);
            check("err_underflow", err_underflow, m_err);
            if (p_stall) begin
                check("hold_data", out_data, p_data);
                check("hold_last", out_last, p_last);
            end
            if (rd_en === 1'b1) rd_log.push_back(cyc - start_cyc);
            if (out_valid === 1'b1 && out_ready) begin
                hs_cyc.push_back(cyc - start_cyc);
                hs_data.push_back(out_data);
                hs_last.push_back(out_last);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc - start_cyc;
            end
        end else begin
            e_rd = 0; e_valid = 0; outst = 0;
        end

        if (res) begin
            m_active = 0; m_abort = 0; m_err = 0; m_done = 0; m_inflt = 0;
            m_len = 0; m_issued = 0; m_hs = 0; m_disc = 0; m_wr = 0;
            eq.delete();
            chk_en = 1;
        end else if (chk_en) begin
            fin = m_active && (m_issued == m_len || m_abort) && (outst == 0);
            nd  = 0;
            if (e_valid && out_ready) begin
                void'(eq.pop_front());
                m_hs++;
                m_wr++;
            end
            if (m_inflt) begin
                if (underflow) begin
                    m_disc++; m_abort = 1; m_err = 1;
                end else begin
                    eq.push_back(rdata);
                end
            end
            if (e_rd) m_issued++;
            m_inflt = e_rd;
            if (fin) begin
                m_active = 0;
                nd = 1;
            end
            if (!m_active && !m_done && !fin && start) begin
                start_cyc = cyc;
                m_len = int'(burst_len);
                m_issued = 0; m_hs = 0; m_disc = 0; m_wr = 0; m_err = 0; m_abort = 0;
                if (burst_len != 0) m_active = 1;
                else nd = 1;
            end
            m_done = nd;
        end

        p_stall = chk_en && !res && (out_valid === 1'b1) && !out_ready;
        p_data  = out_data;
        p_last  = out_last;
        pop_req = (rd_en === 1'b1);
        cyc++;
    end

    //--------------------------------------------------------------------------
    // Stimulus helpers
    //--------------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic fifo_put(input logic [WIDTH-1:0] d);
        fq.push_back(d);
        empty = 1'b0;
    endtask

    task automatic fifo_flush();
        fq.delete();
        empty = 1'b1;
    endtask

    task automatic clear_logs();
        rd_log.delete(); hs_cyc.delete(); hs_data.delete(); hs_last.delete();
        done_cyc = -1;
        rd_cnt = 0;
    endtask

    task automatic start_burst(input int len);
        start = 1'b1;
        burst_len = LEN_W'(len);
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n0;
        int k;
        n0 = done_cnt;
        k = 0;
        while (done_cnt == n0 && k < budget) begin
            tick(1);
            k++;
        end
        check(name, (done_cnt != n0), 1);
    endtask

    //--------------------------------------------------------------------------
    // Directed scenarios
    //--------------------------------------------------------------------------
    initial begin
        int n;
        tick(3);
        res = 1'b0;
        tick(1);
        check("rst_rd_en", rd_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_words", words_read, 0);

        // 1: basic four-word burst, no backpressure
        clear_logs();
        for (int i = 0; i < 4; i++) fifo_put(8'hA1 + 8'(i));
        out_ready = 1'b1;
        start_burst(4);
        wait_done("t1_done_seen", 30);
        check("t1_rd_count", rd_log.size(), 4);
        for (int i = 0; i < 4; i++) check("t1_rd_cycle", rd_log[i], i + 1);
        check("t1_hs_count", hs_data.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t1_data", hs_data[i], 8'hA1 + 8'(i));
            check("t1_hs_cycle", hs_cyc[i], i + 3);
            check("t1_last", hs_last[i], (i == 3));
        end
        check("t1_done_cycle", done_cyc, 8);
        check("t1_words_read", words_read, 4);
        tick(2);

        // 2: consumer stalls through cycle 10
        clear_logs();
        for (int i = 0; i < 6; i++) fifo_put(8'hA1 + 8'(i));
        out_ready = 1'b0;
        start_burst(6);
        tick(9);
        check("t2_rd_before_release", rd_log.size(), 3);
        check("t2_head_valid", out_valid, 1);
        check("t2_head_data", out_data, 8'hA1);
        tick(1);
        out_ready = 1'b1;
        wait_done("t2_done_seen", 40);
        check("t2_hs_count", hs_data.size(), 6);
        for (int i = 0; i < 6; i++) check("t2_data", hs_data[i], 8'hA1 + 8'(i));
        check("t2_last_final", hs_last[5], 1);
        tick(2);

        // 3: FIFO empty until cycle 10
        clear_logs();
        start_burst(5);
        tick(9);
        for (int i = 0; i < 5; i++) fifo_put(8'hC1 + 8'(i));
        wait_done("t3_done_seen", 40);
        check("t3_first_rd", rd_log[0], 10);
        check("t3_rd_count", rd_log.size(), 5);
        check("t3_hs_count", hs_data.size(), 5);
        for (int i = 0; i < 5; i++) check("t3_data", hs_data[i], 8'hC1 + 8'(i));
        check("t3_words_read", words_read, 5);
        tick(2);

        // 4: zero-length burst
        clear_logs();
        start_burst(0);
        wait_done("t4_done_seen", 5);
        check("t4_done_cycle", done_cyc, 1);
        check("t4_rd_count", rd_log.size(), 0);
        check("t4_words_read", words_read, 0);
        tick(2);

        // 5: underflow on the third read response
        clear_logs();
        for (int i = 0; i < 8; i++) fifo_put(8'hD1 + 8'(i));
        force_uf = 3;
        start_burst(8);
        wait_done("t5_done_seen", 30);
        check("t5_err", err_underflow, 1);
        check("t5_rd_count", rd_log.size(), 3);
        check("t5_hs_count", hs_data.size(), 2);
        for (int i = 0; i < 2; i++) begin
            check("t5_data", hs_data[i], 8'hD1 + 8'(i));
            check("t5_no_last", hs_last[i], 0);
        end
        check("t5_done_cycle", done_cyc, 6);
        force_uf = 0;
        tick(2);
        fifo_flush();
        clear_logs();
        fifo_put(8'hE1);
        start_burst(1);
        check("t5_err_cleared", err_underflow, 0);
        wait_done("t5b_done_seen", 20);
        check("t5b_hs_count", hs_data.size(), 1);
        check("t5b_data", hs_data[0], 8'hE1);
        check("t5b_last", hs_last[0], 1);
        tick(2);

        // 6: reset in cycle 5 of an eight-word burst
        clear_logs();
        for (int i = 0; i < 8; i++) fifo_put(8'h91 + 8'(i));
        start_burst(8);
        tick(4);
        res = 1'b1;
        tick(1);
        res = 1'b0;
        check("t6_rd_en", rd_en, 0);
        check("t6_out_valid", out_valid, 0);
        check("t6_out_data", out_data, 0);
        check("t6_out_last", out_last, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_words", words_read, 0);
        check("t6_err", err_underflow, 0);
        n = done_cnt;
        tick(1);
        fifo_flush();
        clear_logs();
        fifo_put(8'h5A);
        fifo_put(8'h5B);
        start_burst(2);
        wait_done("t6b_done_seen", 20);
        check("t6_no_done_on_reset", done_cnt, n + 1);
        check("t6b_hs_count", hs_data.size(), 2);
        check("t6b_data0", hs_data[0], 8'h5A);
        check("t6b_data1", hs_data[1], 8'h5B);
        check("t6b_last", hs_last[1], 1);
        check("t6b_words", words_read, 2);
        tick(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
